// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths and types for the GPR write-port arbiter.
// An LU entry is packed as {pc[68:37], waddr[36:32], wdata[31:0]}.
package rf_wport_arbiter_pkg;

   localparam int RF_ADDR_W      = 5;
   localparam int GR_DATA_W      = 32;
   localparam int PC_W           = 32;
   localparam int LU_ENTRY_WIDTH = PC_W + RF_ADDR_W + GR_DATA_W;

   typedef struct packed {
      logic [PC_W-1:0]      pc;
      logic [RF_ADDR_W-1:0] waddr;
      logic [GR_DATA_W-1:0] wdata;
   } lu_entry_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_WB,
      GRANT_LU
   } grant_e;

endpackage

// File: rtl/lu_result_fifo.sv
// Small synchronous FIFO buffering long-latency unit results.
// The head entry is read combinationally so it can be granted in the same cycle.
module lu_result_fifo
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  lu_entry_t            push_data,
   input  logic                 pop,
   output lu_entry_t            head,
   output logic [$clog2(DEPTH):0] count,
   output logic                 full,
   output logic                 empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   lu_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single GPR write port between the WB stage and buffered LU results,
// stalling WB only for same-register ordering or to bound LU starvation.
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_req,
   input  logic [RF_ADDR_W-1:0] wb_waddr,
   input  logic [GR_DATA_W-1:0] wb_wdata,
   input  logic [PC_W-1:0]      wb_pc,
   output logic                 wb_ready,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [RF_ADDR_W-1:0] lu_waddr,
   input  logic [GR_DATA_W-1:0] lu_wdata,
   input  logic [PC_W-1:0]      lu_pc,
   output logic                 rf_we,
   output logic [RF_ADDR_W-1:0] rf_waddr,
   output logic [GR_DATA_W-1:0] rf_wdata,
   output logic                 lu_pending,
   output logic [PC_W-1:0]      debug_wb_pc,
   output logic [3:0]           debug_wb_rf_we,
   output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
   output logic [GR_DATA_W-1:0] debug_wb_rf_wdata
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   lu_entry_t                  head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;
   logic                       wb_wins_over_lu;
   logic [SC_W-1:0]            starve_cnt;
   grant_e                     grant;

   assign lu_ready   = !reset && !fifo_full;
   assign lu_pending = !reset && (fifo_count != '0);
   assign push       = lu_valid && lu_ready;
   assign pop        = (grant == GRANT_LU);

   lu_result_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data({lu_pc, lu_waddr, lu_wdata}),
      .pop      (pop),
      .head     (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Priority grant: WB-only when empty, drain on WB bubbles, LU first on hazard or starvation
   always_comb begin
      grant           = GRANT_NONE;
      wb_ready        = 1'b1;
      wb_wins_over_lu = 1'b0;
      if (reset) begin
         wb_ready = 1'b0;
      end else if (fifo_empty) begin
         if (wb_req) begin
            grant = GRANT_WB;
         end
      end else if (!wb_req) begin
         grant = GRANT_LU;
      end else if ((head.waddr == wb_waddr) && (wb_waddr != '0)) begin
         grant    = GRANT_LU;
         wb_ready = 1'b0;
      end else if (starve_cnt == SC_W'(STARVE_LIMIT)) begin
         grant    = GRANT_LU;
         wb_ready = 1'b0;
      end else begin
         grant           = GRANT_WB;
         wb_wins_over_lu = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || fifo_empty || pop) begin
         starve_cnt <= '0;
      end else if (wb_wins_over_lu && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

   // Without a grant the port shows the WB values with the enable held low
   always_comb begin
      rf_waddr    = wb_waddr;
      rf_wdata    = wb_wdata;
      debug_wb_pc = wb_pc;
      if (grant == GRANT_LU) begin
         rf_waddr    = head.waddr;
         rf_wdata    = head.wdata;
         debug_wb_pc = head.pc;
      end
      rf_we = (grant != GRANT_NONE) && (rf_waddr != '0);
   end

   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the write-port rules.
module tb_rf_wport_arbiter;
   import rf_wport_arbiter_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_req;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [31:0] wb_pc;
   logic        wb_ready;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic [31:0] lu_pc;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        lu_pending;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int          tests_run    = 0;
   int          tests_failed = 0;
   lu_entry_t   lu_q[$];
   int          starve       = 0;
   logic [31:0] rf_shadow [32];

   always #5 clk = ~clk;

   rf_wport_arbiter #(
      .FIFO_DEPTH  (DEPTH),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .wb_req           (wb_req),
      .wb_waddr         (wb_waddr),
      .wb_wdata         (wb_wdata),
      .wb_pc            (wb_pc),
      .wb_ready         (wb_ready),
      .lu_valid         (lu_valid),
      .lu_ready         (lu_ready),
      .lu_waddr         (lu_waddr),
      .lu_wdata         (lu_wdata),
      .lu_pc            (lu_pc),
      .rf_we            (rf_we),
      .rf_waddr         (rf_waddr),
      .rf_wdata         (rf_wdata),
      .lu_pending       (lu_pending),
      .debug_wb_pc      (debug_wb_pc),
      .debug_wb_rf_we   (debug_wb_rf_we),
      .debug_wb_rf_wnum (debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock of stimulus: drive at negedge, check the combinational outputs, then advance the model
   task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] wp,
                                input logic lv, input logic [4:0] la,
                                input logic [31:0] ld, input logic [31:0] lp);
      lu_entry_t   h;
      logic        use_lu, wb_win, exp_we, exp_wbr, exp_lur, exp_pend, was_empty;
      logic [4:0]  ea;
      logic [31:0] ed, ep;
      @(negedge clk);
      reset = rst;   wb_req = wr;   wb_waddr = wa; wb_wdata = wd; wb_pc = wp;
      lu_valid = lv; lu_waddr = la; lu_wdata = ld; lu_pc = lp;
      #1;
      h       = '0;
      use_lu  = 1'b0;
      wb_win  = 1'b0;
      exp_wbr = 1'b0;
      exp_lur = 1'b0;
      exp_pend = 1'b0;
      if (!rst) begin
         exp_lur  = (lu_q.size() < DEPTH);
         exp_pend = (lu_q.size() != 0);
         exp_wbr  = 1'b1;
         if (lu_q.size() != 0) begin
            h = lu_q[0];
            if (!wr) begin
               use_lu = 1'b1;
            end else if ((h.waddr == wa && wa != 0) || starve == LIMIT) begin
               use_lu  = 1'b1;
               exp_wbr = 1'b0;
            end
         end
         wb_win = wr && !use_lu;
      end
      ea = use_lu ? h.waddr : wa;
      ed = use_lu ? h.wdata : wd;
      ep = use_lu ? h.pc    : wp;
      exp_we = (use_lu || wb_win) && (ea != 0);
      checkOutput("rf_we",      32'(rf_we),      32'(exp_we));
      checkOutput("rf_waddr",   32'(rf_waddr),   32'(ea));
      checkOutput("rf_wdata",   rf_wdata,        ed);
      checkOutput("debug_pc",   debug_wb_pc,     ep);
      checkOutput("wb_ready",   32'(wb_ready),   32'(exp_wbr));
      checkOutput("lu_ready",   32'(lu_ready),   32'(exp_lur));
      checkOutput("lu_pending", 32'(lu_pending), 32'(exp_pend));
      checkOutput("debug_we",   32'(debug_wb_rf_we),    32'({4{exp_we}}));
      checkOutput("debug_wnum", 32'(debug_wb_rf_wnum),  32'(ea));
      checkOutput("debug_wdat", debug_wb_rf_wdata,      ed);
      if (rf_we === 1'b1) begin
         rf_shadow[rf_waddr] = rf_wdata;
      end
      if (rst) begin
         lu_q.delete();
         starve = 0;
      end else begin
         was_empty = (lu_q.size() == 0);
         if (use_lu) begin
            void'(lu_q.pop_front());
         end
         if (lv && exp_lur) begin
            lu_q.push_back('{pc: lp, waddr: la, wdata: ld});
         end
         if (was_empty || use_lu) begin
            starve = 0;
         end else if (wb_win && starve < LIMIT) begin
            starve++;
         end
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_shadow[i] = '0;
      end
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h1, 32'h100, 1'b1, 5'd2, 32'h2, 32'h200);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);

      // WB alone writes in the same cycle
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234, 32'h1000, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("wbonly_we",    32'(rf_we),    32'd1);
      checkOutput("wbonly_addr",  32'(rf_waddr), 32'd3);
      checkOutput("wbonly_data",  rf_wdata,      32'h1234);
      checkOutput("wbonly_ready", 32'(wb_ready), 32'd1);

      // LU into an idle port
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hAA, 32'h2000);
      idleCycle();
      checkOutput("lu_idle_pend", 32'(lu_pending), 32'd1);
      checkOutput("lu_idle_we",   32'(rf_we),      32'd1);
      checkOutput("lu_idle_addr", 32'(rf_waddr),   32'd7);
      idleCycle();
      checkOutput("lu_idle_done", 32'(lu_pending), 32'd0);

      // Ordering hazard on r5
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h5555, 32'h3000);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hBEEF, 32'h3004, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("haz_lu_data",  rf_wdata,      32'h5555);
      checkOutput("haz_stall",    32'(wb_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hBEEF, 32'h3004, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("haz_wb_data",  rf_wdata,      32'hBEEF);
      checkOutput("haz_wb_ready", 32'(wb_ready), 32'd1);
      idleCycle();
      checkOutput("haz_final_r5", rf_shadow[5],  32'hBEEF);

      // Starvation: WB to r4 wins LIMIT cycles, then the r9 entry is forced through
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h9999, 32'h4000);
      for (int i = 0; i < LIMIT; i++) begin
         applyStimulus(1'b0, 1'b1, 5'd4, 32'h40 + 32'(i), 32'h4100, 1'b0, 5'd0, 32'h0, 32'h0);
         checkOutput("starve_wb_addr", 32'(rf_waddr), 32'd4);
      end
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h50, 32'h4100, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("starve_lu_addr", 32'(rf_waddr), 32'd9);
      checkOutput("starve_stall",   32'(wb_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h50, 32'h4100, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("starve_resume",  32'(wb_ready), 32'd1);

      // Full FIFO holds off a third LU result
      applyStimulus(1'b0, 1'b1, 5'd1, 32'h11, 32'h5000, 1'b1, 5'd10, 32'hA0, 32'h5100);
      applyStimulus(1'b0, 1'b1, 5'd1, 32'h12, 32'h5004, 1'b1, 5'd11, 32'hB0, 32'h5104);
      applyStimulus(1'b0, 1'b1, 5'd1, 32'h13, 32'h5008, 1'b1, 5'd12, 32'hC0, 32'h5108);
      checkOutput("full_not_ready", 32'(lu_ready), 32'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 32'hC0, 32'h5108);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 32'hC0, 32'h5108);
      checkOutput("full_freed", 32'(lu_ready), 32'd1);
      idleCycle();
      checkOutput("full_third_addr", 32'(rf_waddr), 32'd12);

      // r0 entry is consumed without a write
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 32'h6000);
      idleCycle();
      checkOutput("r0_no_we", 32'(rf_we), 32'd0);
      idleCycle();
      checkOutput("r0_popped", 32'(lu_pending), 32'd0);

      // Reset with two entries queued
      applyStimulus(1'b0, 1'b1, 5'd2, 32'h21, 32'h7000, 1'b1, 5'd13, 32'hD0, 32'h7100);
      applyStimulus(1'b0, 1'b1, 5'd2, 32'h22, 32'h7004, 1'b1, 5'd14, 32'hE0, 32'h7104);
      applyStimulus(1'b1, 1'b1, 5'd2, 32'h23, 32'h7008, 1'b0, 5'd0, 32'h0, 32'h0);
      checkOutput("rst_no_we", 32'(rf_we), 32'd0);
      idleCycle();
      checkOutput("rst_lu_ready", 32'(lu_ready),   32'd1);
      checkOutput("rst_empty",    32'(lu_pending), 32'd0);

      // Random traffic with a narrow address range to provoke hazards
      for (int i = 0; i < 800; i++) begin
         applyStimulus(1'($urandom_range(0, 59) == 0),
                       1'($urandom_range(0, 2) != 0),
                       5'($urandom_range(0, 7)), $urandom, $urandom,
                       1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 7)), $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Arbiter that shares the single GPR write port between two sources. The in-order pipeline writeback stage is the primary requester. The long-latency unit (divider/multicycle ops) is the secondary requester; it completes out of band. LU results are buffered in a small FIFO. The arbiter back-pressures WB (via its ready_go) only when it must, either to preserve write ordering or to prevent LU starvation.

Parameters:
FIFO_DEPTH, 2, LU result buffer entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles WB may win while the FIFO is non-empty before the FIFO is forced through

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_req  in  1  WB stage holds a valid instruction with gr_we set
wb_waddr  in  5  WB destination register
wb_wdata  in  32  WB result
wb_pc  in  32  WB instruction pc
wb_ready  out  1  WB write accepted this cycle; drives WB_ready_go
lu_valid  in  1  LU result available
lu_ready  out  1  FIFO can accept the LU result
lu_waddr  in  5  LU destination register
lu_wdata  in  32  LU result
lu_pc  in  32  LU instruction pc
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
lu_pending  out  1  FIFO non-empty; used by ID hazard logic
debug_wb_pc  out  32  pc of the granted write
debug_wb_rf_we  out  4  {4{rf_we}}
debug_wb_rf_wnum  out  5  rf_waddr
debug_wb_rf_wdata  out  32  rf_wdata

Behaviour:
- Reset/clock: reset, synchronous, active-high; clock clk.
- Reset state: FIFO empty (rd_ptr = wr_ptr = count = 0), starve_cnt = 0.
- While reset is high: rf_we = 0, wb_ready = 0, lu_ready = 0, lu_pending = 0.
- Enqueue: lu_valid && lu_ready at edge N writes {pc, waddr, wdata} to the FIFO.
  - The entry is eligible for grant from cycle N+1. There is no same-cycle LU bypass.
  - lu_ready = (count < FIFO_DEPTH). Full means not ready, even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. count is updated +1, -1, or unchanged when push and pop coincide.
- Grant decision is combinational, evaluated each cycle in priority order:
  1. FIFO empty: grant WB if wb_req; wb_ready = 1.
  2. FIFO non-empty, wb_req = 0: grant FIFO head (pop); wb_ready = 1.
  3. FIFO non-empty, wb_req, and head.waddr == wb_waddr with wb_waddr != 0 (ordering hazard; LU is older): grant FIFO; wb_ready = 0.
  4. FIFO non-empty, wb_req, starve_cnt == STARVE_LIMIT: grant FIFO; wb_ready = 0.
  5. Otherwise: grant WB; wb_ready = 1.
- wb_ready is 1 whenever wb_req = 0 (WB bubbles always pass).
- starve_cnt update:
  - Cleared on any FIFO pop, or whenever the FIFO is empty.
  - Incremented when rule 5 fires.
  - Saturates at STARVE_LIMIT.
- Port mux: rf_we/rf_waddr/rf_wdata/debug_wb_pc come from the granted source. With no grant, rf_we = 0 and the other outputs hold the WB values.
- r0: a granted write with waddr == 0 drives rf_we = 0 but still consumes the request (pops the entry, or wb_ready = 1).
- Latency: WB path 0 cycles (same-cycle write). LU path minimum 1 cycle after enqueue.
- Worst-case WB stall: 1 cycle per FIFO entry under starvation or hazard.
- Reset mid-operation: FIFO contents are discarded and no write is issued in the reset cycle.

Decomposition:
- Add to constants.h: RF_ADDR_W = 5, GR_DATA_W = 32, and lu_entry_width (pc + waddr + wdata = 69 bits) with its pack order.
- One sub-module: lu_result_fifo (synchronous, parameterised depth, push/pop/count/full/empty, head read combinational).
- Arbitration logic and starve counter stay in the top module.

Test Plan:
- WB only: wb_req = 1, waddr = 3, wdata = 0x1234, FIFO empty -> rf_we = 1, rf_waddr = 3, rf_wdata = 0x1234, wb_ready = 1, same cycle.
- LU into an idle port: lu_valid at cycle 0 (waddr = 7, wdata = 0xAA) -> lu_pending = 1 from cycle 1; rf_we = 1, waddr = 7 in cycle 1; lu_pending = 0 in cycle 2.
- Ordering hazard: FIFO head waddr = 5; WB presents waddr = 5 -> cycle 1 writes LU data with wb_ready = 0; cycle 2 writes WB data with wb_ready = 1; final r5 = WB value.
- Starvation: 1 LU entry (waddr = 9) and continuous WB writes to waddr = 4 -> WB wins 4 cycles, cycle 5 grants the LU with wb_ready = 0, cycle 6 WB resumes.
- Full FIFO: 2 LU pushes with wb_req held high and distinct addresses -> lu_ready = 0 after the 2nd push; a 3rd lu_valid is held with no write until a pop frees an entry.
- r0 and reset: LU entry with waddr = 0 -> pops with rf_we = 0. Reset asserted with 2 entries queued -> count = 0, no rf_we, lu_ready = 1 the cycle after reset deasserts.
